// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and bubble generation (gated ctrl, NOP instr).
module pipe_skid_stage #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned CTRL_W    = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit          SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_instr,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       instr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{valid: 1'b0, ctrl: '0, instr: NOP_INSTR, data: '0};

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{valid: 1'b1, ctrl: in_ctrl, instr: in_instr, data: in_data};

  // With a skid entry, ready comes straight from a flop and never sees out_ready.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = ~s_q.valid;
    end else begin : g_comb_ready
      assign in_ready = ~m_q.valid | out_ready;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_q.valid & out_ready;

  always_comb begin
    // NOTE: hold-current-value defaults first, so every path assigns m_d/s_d and no latch is inferred.
    m_d = m_q;
    s_d = s_q;
    if (flush) begin
      // Payload data is kept; only side-effecting fields are scrubbed.
      m_d.valid = 1'b0;
      m_d.ctrl  = '0;
      m_d.instr = NOP_INSTR;
      s_d.valid = 1'b0;
      s_d.ctrl  = '0;
      s_d.instr = NOP_INSTR;
    end else if (!m_q.valid) begin
      if (in_fire) m_d = in_entry;
    end else if (out_fire) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
      end else if (in_fire) begin
        m_d = in_entry;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (in_fire && SKID) begin
      s_d = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload flops are reset as well because out_data must read 0 after reset.
      m_q <= EMPTY_ENTRY;
      s_q <= EMPTY_ENTRY;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign out_valid = m_q.valid;
  assign out_data  = m_q.data;
  assign out_ctrl  = m_q.valid ? m_q.ctrl : '0;
  assign out_instr = m_q.valid ? m_q.instr : NOP_INSTR;
  assign occupancy = {1'b0, m_q.valid} + {1'b0, s_q.valid};

endmodule
